// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline sequencer: state encoding and drain defaults.
// The debug unit and the testbench import this package as well.
package mips_ctrl_pkg;

    localparam int MC_N_DRAIN  = 3;
    localparam int MC_NB_DRAIN = 2;
    localparam int MC_NB_CYCLE = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } ctrl_state_t;

    // The pipeline advances (and the cycle counter counts) only in these states.
    function automatic logic is_active_state(input ctrl_state_t s);
        return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Request/enable bundle between the pipeline sequencer and the hazard/debug/datapath side.
// The sequencer uses the slave modport; the surrounding logic (or a bench) uses master.
interface pipeline_control_unit_if #(
    parameter int NB_CYCLE = 32
);
    // Requests into the sequencer
    logic                i_start;
    logic                i_step;
    logic                i_halt_id;
    logic                i_risk_detected;
    logic                i_if_flush;

    // Pipeline controls and status out of the sequencer
    logic                o_pc_enable;
    logic                o_if_id_enable;
    logic                o_back_enable;
    logic                o_id_ex_bubble;
    logic                o_if_id_flush;
    logic                o_running;
    logic                o_halted;
    logic                o_step_done;
    logic [NB_CYCLE-1:0] o_cycle_count;

    modport slave (
        input  i_start, i_step, i_halt_id, i_risk_detected, i_if_flush,
        output o_pc_enable, o_if_id_enable, o_back_enable, o_id_ex_bubble,
               o_if_id_flush, o_running, o_halted, o_step_done, o_cycle_count
    );

    modport master (
        output i_start, i_step, i_halt_id, i_risk_detected, i_if_flush,
        input  o_pc_enable, o_if_id_enable, o_back_enable, o_id_ex_bubble,
               o_if_id_flush, o_running, o_halted, o_step_done, o_cycle_count
    );

endinterface

// File: rtl/pipeline_control_unit.sv
// Central sequencer for the 5-stage MIPS pipeline: run/step/halt FSM, stage enables,
// stall bubble, IF/ID flush, HALT drain and a cycle counter for the debug unit.
module pipeline_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int N_DRAIN  = MC_N_DRAIN,
    parameter int NB_DRAIN = MC_NB_DRAIN,
    parameter int NB_CYCLE = MC_NB_CYCLE
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    pipeline_control_unit_if.slave bus
);

    ctrl_state_t           r_state;
    logic [NB_DRAIN-1:0]   r_drain_count;
    logic [NB_CYCLE-1:0]   r_cycle_count;
    logic                  r_halted;
    logic                  r_step_done;

    logic                  w_pc_enable;
    logic                  w_if_id_enable;
    logic                  w_back_enable;
    logic                  w_id_ex_bubble;
    logic                  w_if_id_flush;
    logic                  w_halt_accept;
    logic                  w_active;

    assign w_active = is_active_state(r_state);

    // Stall beats HALT beats flush; a stalled HALT is simply seen again next cycle.
    always_comb begin
        w_pc_enable    = 1'b0;
        w_if_id_enable = 1'b0;
        w_back_enable  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_if_id_flush  = 1'b0;
        w_halt_accept  = 1'b0;
        case (r_state)
            ST_RUN, ST_STEP: begin
                if (bus.i_risk_detected) begin
                    w_back_enable  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                end else if (bus.i_halt_id) begin
                    w_back_enable  = 1'b1;
                    w_halt_accept  = 1'b1;
                end else begin
                    w_pc_enable    = 1'b1;
                    w_if_id_enable = 1'b1;
                    w_back_enable  = 1'b1;
                    w_if_id_flush  = bus.i_if_flush;
                end
            end
            ST_DRAIN: begin
                w_back_enable  = 1'b1;
                w_id_ex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_drain_count <= '0;
            r_cycle_count <= '0;
            r_halted      <= 1'b0;
            r_step_done   <= 1'b0;
        end else begin
            r_step_done <= 1'b0;
            if (w_active) begin
                r_cycle_count <= r_cycle_count + NB_CYCLE'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        r_state <= ST_RUN;
                    end else if (bus.i_step) begin
                        r_state <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (w_halt_accept) begin
                        r_state       <= ST_DRAIN;
                        r_drain_count <= NB_DRAIN'(N_DRAIN - 1);
                    end
                end
                ST_STEP: begin
                    if (w_halt_accept) begin
                        r_state       <= ST_DRAIN;
                        r_drain_count <= NB_DRAIN'(N_DRAIN - 1);
                    end else begin
                        r_state     <= ST_IDLE;
                        r_step_done <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_count == '0) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_drain_count <= r_drain_count - NB_DRAIN'(1);
                    end
                end
                ST_HALTED: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_pc_enable    = w_pc_enable;
    assign bus.o_if_id_enable = w_if_id_enable;
    assign bus.o_back_enable  = w_back_enable;
    assign bus.o_id_ex_bubble = w_id_ex_bubble;
    assign bus.o_if_id_flush  = w_if_id_flush;
    assign bus.o_running      = w_active;
    assign bus.o_halted       = r_halted;
    assign bus.o_step_done    = r_step_done;
    assign bus.o_cycle_count  = r_cycle_count;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit: a 32-bit counter instance for the sequencing
// scenarios and a 4-bit counter instance for the wrap case.
module tb_pipeline_control_unit;
    import mips_ctrl_pkg::*;

    logic clk;
    logic srst;
    int   checks;
    int   errors;

    pipeline_control_unit_if #(.NB_CYCLE(32)) bus  ();
    pipeline_control_unit_if #(.NB_CYCLE(4))  bus4 ();

    pipeline_control_unit #(.N_DRAIN(MC_N_DRAIN), .NB_DRAIN(2), .NB_CYCLE(32)) dut (
        .i_clock (clk),
        .i_reset (srst),
        .bus     (bus.slave)
    );

    pipeline_control_unit #(.N_DRAIN(MC_N_DRAIN), .NB_DRAIN(2), .NB_CYCLE(4)) dut4 (
        .i_clock (clk),
        .i_reset (srst),
        .bus     (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Enables packed as {pc, if_id, back, bubble, flush}
    function automatic logic [31:0] en_vec();
        return {27'd0, bus.o_pc_enable, bus.o_if_id_enable, bus.o_back_enable,
                bus.o_id_ex_bubble, bus.o_if_id_flush};
    endfunction

    task automatic clear_inputs();
        bus.i_start = 0; bus.i_step = 0; bus.i_halt_id = 0;
        bus.i_risk_detected = 0; bus.i_if_flush = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        srst = 1'b1;
        tick();
        tick();
        srst = 1'b0;
        settle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus4.i_start = 0; bus4.i_step = 0; bus4.i_halt_id = 0;
        bus4.i_risk_detected = 0; bus4.i_if_flush = 0;
        do_reset();

        // Reset state held for 5 cycles with no start
        for (int i = 0; i < 5; i++) begin
            chk("rst_enables", en_vec(), 32'b00000);
            chk("rst_count", bus.o_cycle_count, 0);
            tick();
        end
        chk("rst_halted", {31'd0, bus.o_halted}, 0);
        chk("rst_running", {31'd0, bus.o_running}, 0);

        // Start, flush passthrough, load-use stall
        bus.i_start = 1; settle();
        chk("idle_start_frozen", en_vec(), 32'b00000);
        tick(); bus.i_start = 0; settle();
        chk("run1_enables", en_vec(), 32'b11100);
        chk("run1_running", {31'd0, bus.o_running}, 1);
        tick();
        bus.i_if_flush = 1; settle();
        chk("run2_flush", en_vec(), 32'b11101);
        tick(); bus.i_if_flush = 0;
        bus.i_risk_detected = 1; settle();
        chk("run3_stall", en_vec(), 32'b00110);
        tick(); bus.i_risk_detected = 0; settle();
        chk("run4_after_stall", en_vec(), 32'b11100);
        tick(); tick();
        chk("run_count5", bus.o_cycle_count, 5);

        // Risk+flush+halt together -> stall only, then HALT accepted
        bus.i_risk_detected = 1; bus.i_if_flush = 1; bus.i_halt_id = 1; settle();
        chk("triple_stall", en_vec(), 32'b00110);
        tick();
        bus.i_risk_detected = 0; bus.i_if_flush = 0; settle();
        chk("halt_accept", en_vec(), 32'b00100);
        tick(); bus.i_halt_id = 0;
        bus.i_if_flush = 1; bus.i_risk_detected = 1; settle();
        chk("drain1_enables", en_vec(), 32'b00110);
        chk("drain1_halted", {31'd0, bus.o_halted}, 0);
        tick(); bus.i_if_flush = 0; bus.i_risk_detected = 0; settle();
        chk("drain2_running", {31'd0, bus.o_running}, 1);
        tick();
        chk("drain3_halted", {31'd0, bus.o_halted}, 0);
        tick();
        chk("halted_rise", {31'd0, bus.o_halted}, 1);
        chk("halted_running", {31'd0, bus.o_running}, 0);
        chk("halted_enables", en_vec(), 32'b00000);
        chk("halted_count", bus.o_cycle_count, 10);
        bus.i_start = 1; tick(); tick(); bus.i_start = 0; settle();
        chk("halted_start_ign", {31'd0, bus.o_halted}, 1);
        chk("halted_count_hold", bus.o_cycle_count, 10);

        // Single step, then a stalled step
        do_reset();
        chk("reset_clears_halt", {31'd0, bus.o_halted}, 0);
        bus.i_step = 1; tick(); bus.i_step = 0; settle();
        chk("step_enables", en_vec(), 32'b11100);
        chk("step_done_during", {31'd0, bus.o_step_done}, 0);
        tick();
        chk("step_done_pulse", {31'd0, bus.o_step_done}, 1);
        chk("step_back_idle", {31'd0, bus.o_running}, 0);
        chk("step_count", bus.o_cycle_count, 1);
        tick();
        chk("step_done_clear", {31'd0, bus.o_step_done}, 0);
        bus.i_step = 1; tick(); bus.i_step = 0;
        bus.i_risk_detected = 1; settle();
        chk("step_stall_en", en_vec(), 32'b00110);
        tick(); bus.i_risk_detected = 0; settle();
        chk("step_stall_done", {31'd0, bus.o_step_done}, 1);
        chk("step_stall_count", bus.o_cycle_count, 2);

        // Start and step together -> RUN, no step_done
        bus.i_start = 1; bus.i_step = 1; tick();
        bus.i_start = 0; bus.i_step = 0; tick();
        chk("startstep_running", {31'd0, bus.o_running}, 1);
        chk("startstep_no_done", {31'd0, bus.o_step_done}, 0);
        tick();
        chk("startstep_still", {31'd0, bus.o_running}, 1);

        // HALT during STEP
        do_reset();
        bus.i_step = 1; tick(); bus.i_step = 0;
        bus.i_halt_id = 1; settle();
        chk("step_halt_en", en_vec(), 32'b00100);
        tick(); bus.i_halt_id = 0; settle();
        chk("step_halt_drain", en_vec(), 32'b00110);
        chk("step_halt_nodone", {31'd0, bus.o_step_done}, 0);
        tick(); tick();
        chk("step_halt_d3", {31'd0, bus.o_halted}, 0);
        tick();
        chk("step_halt_halted", {31'd0, bus.o_halted}, 1);
        chk("step_halt_nodone2", {31'd0, bus.o_step_done}, 0);
        chk("step_halt_count", bus.o_cycle_count, 4);
        bus.i_start = 1; tick(); bus.i_start = 0; settle();
        chk("step_halt_start_ign", en_vec(), 32'b00000);

        // Reset during the second DRAIN cycle
        do_reset();
        bus.i_start = 1; tick(); bus.i_start = 0;
        bus.i_halt_id = 1; tick(); bus.i_halt_id = 0;
        tick(); settle();
        chk("mid_drain_running", {31'd0, bus.o_running}, 1);
        srst = 1; tick(); srst = 0; settle();
        chk("mid_drain_rst_run", {31'd0, bus.o_running}, 0);
        chk("mid_drain_rst_cnt", bus.o_cycle_count, 0);
        chk("mid_drain_rst_hlt", {31'd0, bus.o_halted}, 0);
        chk("mid_drain_rst_en", en_vec(), 32'b00000);

        // 4-bit counter wraps after 17 RUN cycles
        chk("wrap_idle_count", {28'd0, bus4.o_cycle_count}, 0);
        bus4.i_start = 1; tick(); bus4.i_start = 0;
        for (int i = 0; i < 17; i++) tick();
        chk("wrap_count", {28'd0, bus4.o_cycle_count}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_control_unit.md
Name: pipeline_control_unit

Overview:
- Central sequencer for the 5-stage MIPS pipeline.
- Combines the hazard unit's load-use stall and branch/jump flush with the debug-unit run/step commands and HALT detection.
- Drives per-stage register enables, the ID/EX bubble and the IF/ID flush.
- Drains the pipeline cleanly on HALT and exposes run status and a cycle counter to the debug unit.

Parameters:
- N_DRAIN, 3, cycles spent draining EX/MEM/WB after HALT is accepted in ID.
- NB_DRAIN, 2, width of the drain counter; must hold N_DRAIN.
- NB_CYCLE, 32, width of the cycle counter.

Ports:
- i_clock  input  1  system clock.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  debug-unit pulse: begin continuous execution.
- i_step  input  1  debug-unit pulse: advance the pipeline exactly one cycle.
- i_halt_id  input  1  HALT opcode decoded in ID.
- i_risk_detected  input  1  load-use stall request from the hazard unit.
- i_if_flush  input  1  branch/jump flush request from the hazard unit.
- o_pc_enable  output  1  PC register load enable.
- o_if_id_enable  output  1  IF/ID register load enable.
- o_back_enable  output  1  common enable for the ID/EX, EX/MEM and MEM/WB registers.
- o_id_ex_bubble  output  1  zero the control fields loaded into ID/EX (insert NOP).
- o_if_id_flush  output  1  clear IF/ID on the next edge.
- o_running  output  1  state is RUN, STEP or DRAIN.
- o_halted  output  1  registered; state is HALTED.
- o_step_done  output  1  registered one-cycle pulse after a step completes.
- o_cycle_count  output  NB_CYCLE  cycles executed since reset.

Behaviour:
- One clock (i_clock); reset synchronous, active-high (i_reset). Reset mid-operation is permitted in any state.
- Reset effects: state goes to IDLE, drain counter and cycle counter clear, o_halted and o_step_done clear.
- States: IDLE, RUN, STEP, DRAIN, HALTED. State encoding lives in the package.
- Enables, bubble and flush are combinational decodes of state and inputs.
- In IDLE and HALTED, every enable, bubble and flush output is 0. The pipeline is frozen.
- Active cycle (state RUN or STEP), evaluated in this priority order:
  1. i_risk_detected=1: o_pc_enable=0, o_if_id_enable=0, o_back_enable=1, o_id_ex_bubble=1, o_if_id_flush=0. Flush and HALT are ignored this cycle and re-evaluated next cycle.
  2. i_halt_id=1: o_pc_enable=0, o_if_id_enable=0, o_back_enable=1, o_id_ex_bubble=0 (the HALT itself enters EX). Next state DRAIN; drain counter loads N_DRAIN-1.
  3. Otherwise: all three enables = 1, o_id_ex_bubble=0, o_if_id_flush=i_if_flush.
- IDLE transitions: i_start -> RUN; i_step -> STEP; both asserted together -> RUN.
- RUN: stays in RUN until HALT is accepted. i_start and i_step are ignored.
- STEP: lasts exactly one cycle.
  - If no HALT is accepted, next state IDLE and o_step_done=1 for one cycle (the cycle after STEP).
  - A stalled step still counts as done; the stalled instruction stays in IF/ID.
  - HALT accepted in STEP -> DRAIN. No step_done pulse.
- DRAIN:
  - o_pc_enable=0, o_if_id_enable=0, o_back_enable=1, o_id_ex_bubble=1, o_if_id_flush=0.
  - i_risk_detected, i_if_flush and i_halt_id are ignored.
  - Drain counter decrements each cycle. At 0, next state HALTED.
  - DRAIN lasts exactly N_DRAIN cycles.
- HALTED: terminal state; only i_reset exits it. o_halted=1 from the first HALTED cycle.
- o_cycle_count: increments by 1 in every RUN, STEP or DRAIN cycle, stalled cycles included. It wraps modulo 2^NB_CYCLE and holds in IDLE and HALTED.
- o_running: combinational, true in RUN, STEP and DRAIN.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state encoding constants (IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4, 3 bits);
  - the N_DRAIN default, so the debug unit and testbench agree.
- No sub-module. The FSM, drain counter and cycle counter fit in one module.

Test Plan:
- Reset check: reset, then no start for 5 cycles -> all enables 0, o_cycle_count=0, o_halted=0.
- Start, then load-use: i_start; at cycle 3 assert i_risk_detected for 1 cycle -> that cycle o_pc_enable=0, o_if_id_enable=0, o_id_ex_bubble=1, o_back_enable=1; next cycle all enables 1. Count after 5 RUN cycles = 5.
- Simultaneous risk+flush+halt in RUN -> stall only; next cycle (risk low, halt high) -> DRAIN entered. o_halted rises exactly N_DRAIN+1 cycles after HALT acceptance; o_cycle_count then frozen.
- Single step: from IDLE pulse i_step -> exactly one cycle with all enables 1, then o_step_done=1 for one cycle, state IDLE. i_start and i_step together -> RUN, no step_done.
- HALT during STEP: i_step with i_halt_id=1 -> DRAIN for 3 cycles, then HALTED, no o_step_done. i_start while HALTED -> ignored.
- Reset mid-DRAIN and cycle-count wrap: assert i_reset in 2nd DRAIN cycle -> IDLE next edge, counters 0. With NB_CYCLE=4, run 17 cycles -> o_cycle_count=1.
